// File: rtl/disparity_pkg.sv
// Shared constants and candidate type for the disparity-map pipeline.
// wta_cand_t pairs a fused cost with the disparity index it belongs to.
package disparity_pkg;

  localparam int NUM_DISP = 256;
  localparam int COST_W   = 5;
  localparam int DISP_W   = 8;

  typedef struct packed {
    logic [COST_W-1:0] cost;
    logic [DISP_W-1:0] idx;
  } wta_cand_t;

endpackage

// File: rtl/wta_min_node.sv
// Two-input min select on {cost, idx} candidates.
// The left (lower-index) input wins unless the right is strictly cheaper.
module wta_min_node
  import disparity_pkg::*;
(
  input  wta_cand_t i_a,
  input  wta_cand_t i_b,
  output wta_cand_t o_win
);

  assign o_win = (i_b.cost < i_a.cost) ? i_b : i_a;

endmodule

// File: rtl/wta_disparity_select.sv
// Winner-take-all disparity select: 256-way min tree, 4-stage pipeline.
// Optional threshold flag disp_invalid when WTA_INVALID_EN is defined.
module wta_disparity_select #(
  parameter int NUM_DISP = 256,
  parameter int COST_W   = 5,
  parameter int DISP_W   = 8
`ifdef WTA_INVALID_EN
  ,
  parameter logic [4:0] INVALID_THRESH = 5'd24
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clken,
  input  logic                       cost_valid,
  input  logic [NUM_DISP*COST_W-1:0] cost_fusion,
  output logic                       valid,
  output logic [DISP_W-1:0]          disparity,
  output logic [COST_W-1:0]          min_cost
`ifdef WTA_INVALID_EN
  ,
  output logic                       disp_invalid
`endif
);

  import disparity_pkg::*;

  wta_cand_t w_l0 [NUM_DISP];
  wta_cand_t w_l1 [NUM_DISP/2];
  wta_cand_t w_l2 [NUM_DISP/4];
  wta_cand_t w_l3 [NUM_DISP/8];
  wta_cand_t w_l4 [NUM_DISP/16];
  wta_cand_t w_l5 [NUM_DISP/32];
  wta_cand_t w_l6 [NUM_DISP/64];
  wta_cand_t w_l7 [NUM_DISP/128];
  wta_cand_t w_l8;

  wta_cand_t r_s1 [NUM_DISP/4];
  wta_cand_t r_s2 [NUM_DISP/16];
  wta_cand_t r_s3 [NUM_DISP/64];
  wta_cand_t r_s4;
  logic [3:0] r_vld;

  // Index is bound by position; it rides along with the cost.
  for (genvar g = 0; g < NUM_DISP; g++) begin : g_l0
    assign w_l0[g].cost = cost_fusion[g*COST_W +: COST_W];
    assign w_l0[g].idx  = DISP_W'(g);
  end

  for (genvar g = 0; g < NUM_DISP/2; g++) begin : g_l1
    wta_min_node u_n (
      .i_a   (w_l0[2*g]),
      .i_b   (w_l0[2*g+1]),
      .o_win (w_l1[g])
    );
  end

  for (genvar g = 0; g < NUM_DISP/4; g++) begin : g_l2
    wta_min_node u_n (
      .i_a   (w_l1[2*g]),
      .i_b   (w_l1[2*g+1]),
      .o_win (w_l2[g])
    );
  end

  for (genvar g = 0; g < NUM_DISP/8; g++) begin : g_l3
    wta_min_node u_n (
      .i_a   (r_s1[2*g]),
      .i_b   (r_s1[2*g+1]),
      .o_win (w_l3[g])
    );
  end

  for (genvar g = 0; g < NUM_DISP/16; g++) begin : g_l4
    wta_min_node u_n (
      .i_a   (w_l3[2*g]),
      .i_b   (w_l3[2*g+1]),
      .o_win (w_l4[g])
    );
  end

  for (genvar g = 0; g < NUM_DISP/32; g++) begin : g_l5
    wta_min_node u_n (
      .i_a   (r_s2[2*g]),
      .i_b   (r_s2[2*g+1]),
      .o_win (w_l5[g])
    );
  end

  for (genvar g = 0; g < NUM_DISP/64; g++) begin : g_l6
    wta_min_node u_n (
      .i_a   (w_l5[2*g]),
      .i_b   (w_l5[2*g+1]),
      .o_win (w_l6[g])
    );
  end

  for (genvar g = 0; g < NUM_DISP/128; g++) begin : g_l7
    wta_min_node u_n (
      .i_a   (r_s3[2*g]),
      .i_b   (r_s3[2*g+1]),
      .o_win (w_l7[g])
    );
  end

  wta_min_node u_l8 (
    .i_a   (w_l7[0]),
    .i_b   (w_l7[1]),
    .o_win (w_l8)
  );

  // Data advances on clken even for bubbles; only r_vld marks them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_s1  <= '{default: '0};
      r_s2  <= '{default: '0};
      r_s3  <= '{default: '0};
      r_s4  <= '0;
    end else if (clken) begin
      r_vld <= {r_vld[2:0], cost_valid};
      r_s1  <= w_l2;
      r_s2  <= w_l4;
      r_s3  <= w_l6;
      r_s4  <= w_l8;
    end
  end

`ifdef WTA_INVALID_EN
  logic r_inv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inv <= 1'b0;
    end else if (clken) begin
      r_inv <= (w_l8.cost >= INVALID_THRESH);
    end
  end

  assign disp_invalid = r_inv;
`endif

  assign valid     = r_vld[3];
  assign disparity = r_s4.idx;
  assign min_cost  = r_s4.cost;

endmodule

// File: tb/tb_wta_disparity_select.sv
// Directed bench for wta_disparity_select: latency, ties, stalls,
// bubbles and mid-stream reset, with hand-computed expectations.
module tb_wta_disparity_select;

  logic          clk = 1'b0;
  logic          rst;
  logic          clken;
  logic          cost_valid;
  logic [1279:0] cost_fusion;
  logic          valid;
  logic [7:0]    disparity;
  logic [4:0]    min_cost;
`ifdef WTA_INVALID_EN
  logic          disp_invalid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wta_disparity_select dut (
    .clk          (clk),
    .rst          (rst),
    .clken        (clken),
    .cost_valid   (cost_valid),
    .cost_fusion  (cost_fusion),
    .valid        (valid),
    .disparity    (disparity),
    .min_cost     (min_cost)
`ifdef WTA_INVALID_EN
    ,
    .disp_invalid (disp_invalid)
`endif
  );

  function automatic logic [1279:0] vec1(input int d,
                                         input logic [4:0] c);
    logic [1279:0] v;
    v = {256{5'd31}};
    v[d*5 +: 5] = c;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1279:0] v);
    cost_fusion = v;
    cost_valid  = 1'b1;
    tick();
    cost_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clken = 1'b1;
    cost_valid = 1'b0;
    cost_fusion = '0;
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", valid);
    end
    checks++;
    if (disparity !== 8'd0) begin
      errors++;
      $display("FAIL reset_disp got %0d want 0", disparity);
    end
    checks++;
    if (min_cost !== 5'd0) begin
      errors++;
      $display("FAIL reset_cost got %0d want 0", min_cost);
    end
`ifdef WTA_INVALID_EN
    checks++;
    if (disp_invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_inv got %0b want 0", disp_invalid);
    end
`endif
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    send(vec1(100, 5'd3));
    tick();
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got %0b want 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid got %0b want 1", valid);
    end
    checks++;
    if (disparity !== 8'd100) begin
      errors++;
      $display("FAIL single_disp got %0d want 100", disparity);
    end
    checks++;
    if (min_cost !== 5'd3) begin
      errors++;
      $display("FAIL single_cost got %0d want 3", min_cost);
    end
  endtask

  task automatic test_tie();
    logic [1279:0] v;
    v = vec1(7, 5'd0);
    v[200*5 +: 5] = 5'd0;
    send(v);
    repeat (3) tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL tie_valid got %0b want 1", valid);
    end
    checks++;
    if (disparity !== 8'd7) begin
      errors++;
      $display("FAIL tie_disp got %0d want 7", disparity);
    end
    checks++;
    if (min_cost !== 5'd0) begin
      errors++;
      $display("FAIL tie_cost got %0d want 0", min_cost);
    end
  endtask

  task automatic test_all_equal();
    send({256{5'd31}});
    repeat (3) tick();
    checks++;
    if (disparity !== 8'd0) begin
      errors++;
      $display("FAIL eq_disp got %0d want 0", disparity);
    end
    checks++;
    if (min_cost !== 5'd31) begin
      errors++;
      $display("FAIL eq_cost got %0d want 31", min_cost);
    end
`ifdef WTA_INVALID_EN
    checks++;
    if (disp_invalid !== 1'b1) begin
      errors++;
      $display("FAIL eq_inv got %0b want 1", disp_invalid);
    end
`endif
    send(vec1(50, 5'd23));
    repeat (3) tick();
    checks++;
    if (disparity !== 8'd50) begin
      errors++;
      $display("FAIL eq50_disp got %0d want 50", disparity);
    end
    checks++;
    if (min_cost !== 5'd23) begin
      errors++;
      $display("FAIL eq50_cost got %0d want 23", min_cost);
    end
`ifdef WTA_INVALID_EN
    checks++;
    if (disp_invalid !== 1'b0) begin
      errors++;
      $display("FAIL eq50_inv got %0b want 0", disp_invalid);
    end
`endif
  endtask

  task automatic test_stream_stall();
    send(vec1(10, 5'd1));
    send(vec1(20, 5'd2));
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cost_valid = 1'b1;
      cost_fusion = vec1(99, 5'd0);
      tick();
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL stall1_valid[%0d] got %0b want 0", i, valid);
      end
    end
    cost_valid = 1'b0;
    clken = 1'b1;
    send(vec1(30, 5'd3));
    tick();
    checks++;
    if (valid !== 1'b1 || disparity !== 8'd10) begin
      errors++;
      $display("FAIL stream_a got v%0b d%0d want v1 d10",
               valid, disparity);
    end
    clken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || disparity !== 8'd10) begin
        errors++;
        $display("FAIL stall2_hold[%0d] got v%0b d%0d want v1 d10",
                 i, valid, disparity);
      end
    end
    clken = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b1 || disparity !== 8'd20) begin
      errors++;
      $display("FAIL stream_b got v%0b d%0d want v1 d20",
               valid, disparity);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || disparity !== 8'd30) begin
      errors++;
      $display("FAIL stream_c got v%0b d%0d want v1 d30",
               valid, disparity);
    end
    checks++;
    if (min_cost !== 5'd3) begin
      errors++;
      $display("FAIL stream_c_cost got %0d want 3", min_cost);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end got %0b want 0", valid);
    end
  endtask

  task automatic test_bubble();
    send(vec1(60, 5'd2));
    cost_fusion = vec1(61, 5'd2);
    cost_valid = 1'b0;
    tick();
    send(vec1(62, 5'd2));
    tick();
    checks++;
    if (valid !== 1'b1 || disparity !== 8'd60) begin
      errors++;
      $display("FAIL bubble_0 got v%0b d%0d want v1 d60",
               valid, disparity);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL bubble_1 got %0b want 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || disparity !== 8'd62) begin
      errors++;
      $display("FAIL bubble_2 got v%0b d%0d want v1 d62",
               valid, disparity);
    end
  endtask

  task automatic test_reset_mid();
    send(vec1(11, 5'd1));
    send(vec1(12, 5'd1));
    send(vec1(13, 5'd1));
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || disparity !== 8'd0 || min_cost !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_now got v%0b d%0d c%0d want 0 0 0",
               valid, disparity, min_cost);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale[%0d] got %0b want 0", i, valid);
      end
    end
    send(vec1(255, 5'd4));
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_early[%0d] got %0b want 0", i, valid);
      end
    end
    tick();
    checks++;
    if (valid !== 1'b1 || disparity !== 8'd255) begin
      errors++;
      $display("FAIL rstmid_new got v%0b d%0d want v1 d255",
               valid, disparity);
    end
    checks++;
    if (min_cost !== 5'd4) begin
      errors++;
      $display("FAIL rstmid_cost got %0d want 4", min_cost);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_all_equal();
    test_stream_stall();
    test_bubble();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wta_disparity_select.md
# wta_disparity_select

Winner-take-all disparity selector for the disparity-map pipeline. Consumes the fused per-pixel cost vector (256 disparities × 5-bit cost) produced by the cost-fusion stage. It returns the disparity index with the minimum cost through a fixed-latency, clock-enable-gated reduction pipeline. Its output feeds the disparity-map writer and post-filtering.

## Interface
Parameters:
- `NUM_DISP`, 256: disparity candidates per pixel. Fixed at 256; other values are unsupported.
- `COST_W`, 5: fused cost width, unsigned.
- `DISP_W`, 8: disparity index width.
- `INVALID_THRESH`, 5'd24: minimum-cost threshold. Used only when `WTA_INVALID_EN` is defined.

Ports:
- `clk`, in, 1: sole clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous active-low reset.
- `clken`, in, 1: pipeline advance enable. When low, all registers hold.
- `cost_valid`, in, 1: `cost_fusion` carries a real pixel this cycle.
- `cost_fusion`, in, 1280: cost of disparity d in bits [d*5+4 : d*5].
- `valid`, out, 1: `disparity`/`min_cost` hold a result.
- `disparity`, out, 8: index of the minimum cost.
- `min_cost`, out, 5: minimum cost value.
- `disp_invalid`, out, 1: result rejected by the threshold. Present only with `WTA_INVALID_EN`.

## Operation
- Each candidate is the pair {cost, index}, indices 0..255 bound by position.
- Reduction is a binary tree of 8 levels, 256 → 1.
- Each node outputs the left (lower-index) candidate unless right.cost < left.cost (strict). So ties always resolve to the lowest index.
- Pipeline registers sit after tree levels 2, 4, 6 and 8, holding 64, 16, 4 and 1 candidates respectively.
- `valid` travels through a 4-bit shift chain that samples `cost_valid`. A bubble on input (`cost_valid`=0) yields `valid`=0 in the matching output slot.
- Data registers advance with `clken` regardless of `cost_valid`. Outputs with `valid`=0 are don't-care for consumers, but are deterministic.
- No arithmetic beyond unsigned 5-bit compare. The index is carried, not computed.

## Timing
- Latency is 4 `clken`-qualified rising edges. An input sampled at edge n (with `clken`=1) appears on the outputs after edge n+3 of enabled edges.
- Throughput is one pixel per enabled cycle, with no backpressure.
- With `clken`=0, every register, including the valid chain, holds. Results are neither lost nor duplicated across any stall length.
- Reset: on `rst` low, immediately and asynchronously, `valid`=0, `disparity`=0, `min_cost`=0, `disp_invalid`=0, and all pipeline and valid-chain registers clear.
- Reset mid-stream discards all in-flight pixels. After release, the first `valid`=1 comes 4 enabled edges after the first `cost_valid`=1 sample.
- `clken` and `cost_valid` may toggle every cycle independently.

## Configuration
- Macro: `WTA_INVALID_EN`.
- Defined: the final stage registers `disp_invalid` = (min_cost >= `INVALID_THRESH`). This is computed in the same edge as `min_cost`, adding no latency. `disparity` is still reported.
- Undefined: the port and comparator are absent. All other behaviour is identical.

## Structure
- Shared package `disparity_pkg` holds:
  - constants `NUM_DISP`, `COST_W`, `DISP_W`;
  - typedef `wta_cand_t` = {cost[4:0], idx[7:0]}.
- Sub-module `wta_min_node`: combinational 2-input compare/select on `wta_cand_t` with lower-index tie preference. It is instantiated per tree node through generate loops.
- The top level holds the stage registers, the valid chain and the optional threshold logic.

## Test plan
- Single minimum:
  - Stimulus: all costs 31 except d=100 set to 3, `clken`=1.
  - Expected: `valid`=1 after 4 edges, `disparity`=100, `min_cost`=3.
- Tie-break:
  - Stimulus: d=7 and d=200 both cost 0, all others 31.
  - Expected: `disparity`=7, `min_cost`=0.
- All equal:
  - Stimulus: every cost 31.
  - Expected: `disparity`=0, `min_cost`=31.
  - With `WTA_INVALID_EN` and `INVALID_THRESH`=24, also `disp_invalid`=1.
  - With d=50 set to 23: `disparity`=50, `disp_invalid`=0.
- Stream with stall:
  - Stimulus: vectors A, B, C back-to-back (minima at 10, 20, 30), then `clken` low for 3 cycles after B is accepted.
  - Expected: outputs 10, 20, 30 in order; outputs frozen during the stall; no duplicates or drops.
- Bubble:
  - Stimulus: `cost_valid` pattern 1,0,1.
  - Expected: output `valid` pattern 1,0,1 starting 4 edges later.
- Reset mid-stream:
  - Stimulus: assert `rst` low with 3 pixels in flight.
  - Expected: `valid` and all outputs 0 immediately. After release, a new pixel with minimum at d=255 produces `valid`=1, `disparity`=255 exactly 4 enabled edges later, with no stale results.
